// File: rtl/video_mixer_pipe.sv
// video_mixer_pipe: registered RGB / YPbPr output stage with scanline dimming, 3-cycle latency.
// Define VIDEO_MIXER_PIPE_YPBPR_FULL_EN to enable full-range YPbPr expansion via ypbpr_full.
module video_mixer_pipe #(
  parameter int COLOR_W = 8,
  parameter int OUT_W   = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [1:0]         scanlines,
  input  logic               scanline_alt,
  input  logic               ypbpr,
  input  logic               ypbpr_full,
  input  logic               csync,
  input  logic [COLOR_W-1:0] R,
  input  logic [COLOR_W-1:0] G,
  input  logic [COLOR_W-1:0] B,
  input  logic               HSync,
  input  logic               VSync,
  input  logic               HBlank,
  input  logic               VBlank,
  output logic [OUT_W-1:0]   VGA_R,
  output logic [OUT_W-1:0]   VGA_G,
  output logic [OUT_W-1:0]   VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS
);

  function automatic logic [7:0] shade(input logic [7:0] x, input logic [1:0] level,
                                       input logic dim);
    logic [7:0] y;
    y = x;
    if (dim) begin
      case (level)
        2'b01:   y = (x >> 1) + (x >> 2);
        2'b10:   y = x >> 1;
        2'b11:   y = x >> 2;
        default: y = x;
      endcase
    end
    return y;
  endfunction

  function automatic logic [7:0] clamp_int(input logic [9:0] ip, input logic [7:0] hi);
    logic [7:0] v;
    if (ip < 10'd16)            v = 8'd16;
    else if (ip > {2'b00, hi})  v = hi;
    else                        v = ip[7:0];
    return v;
  endfunction

  // MSB replication keeps full white at 8'hFF for narrow cores
  logic [7:0] r_w, g_w, b_w;
  generate
    if (COLOR_W == 8) begin : g_no_widen
      assign r_w = R;
      assign g_w = G;
      assign b_w = B;
    end else begin : g_widen
      assign r_w = {R, R[COLOR_W-1 -: 8-COLOR_W]};
      assign g_w = {G, G[COLOR_W-1 -: 8-COLOR_W]};
      assign b_w = {B, B[COLOR_W-1 -: 8-COLOR_W]};
    end
  endgenerate

  logic       old_hs, old_vs, parity;
  logic       blank, dim_on;
  logic [7:0] r1, g1, b1;
  logic       hs1, vs1;

  assign blank  = HBlank | VBlank;
  assign dim_on = parity ^ scanline_alt;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      old_hs <= 1'b0;
      old_vs <= 1'b0;
      parity <= 1'b0;
      r1     <= 8'd0;
      g1     <= 8'd0;
      b1     <= 8'd0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
    end else begin
      old_hs <= HSync;
      old_vs <= VSync;
      // frame start re-anchors the line parity even if a line ends on the same cycle
      if (old_vs && !VSync)      parity <= 1'b0;
      else if (old_hs && !HSync) parity <= ~parity;
      r1  <= shade(blank ? 8'd0 : r_w, scanlines, dim_on);
      g1  <= shade(blank ? 8'd0 : g_w, scanlines, dim_on);
      b1  <= shade(blank ? 8'd0 : b_w, scanlines, dim_on);
      hs1 <= HSync;
      vs1 <= VSync;
    end
  end

  // BT.601 limited-range matrix in 8.8 fixed point; offsets keep every sum positive
  logic [18:0] r_x, g_x, b_x, y_sum, pb_sum, pr_sum;
  assign r_x = {11'd0, r1};
  assign g_x = {11'd0, g1};
  assign b_x = {11'd0, b1};

  always_comb begin
    y_sum  = 19'd4096  + 19'd66  * r_x + 19'd129 * g_x + 19'd25  * b_x;
    pb_sum = 19'd32768 - 19'd38  * r_x - 19'd74  * g_x + 19'd112 * b_x;
    pr_sum = 19'd32768 + 19'd112 * r_x - 19'd94  * g_x - 19'd18  * b_x;
  end

  logic [7:0]  r2, g2, b2;
  logic [18:0] y2, pb2, pr2;
  logic        hs2, vs2;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r2  <= 8'd0;
      g2  <= 8'd0;
      b2  <= 8'd0;
      y2  <= 19'd0;
      pb2 <= 19'd0;
      pr2 <= 19'd0;
      hs2 <= 1'b0;
      vs2 <= 1'b0;
    end else begin
      r2  <= r1;
      g2  <= g1;
      b2  <= b1;
      y2  <= y_sum;
      pb2 <= pb_sum;
      pr2 <= pr_sum;
      hs2 <= hs1;
      vs2 <= vs1;
    end
  end

  logic unused_sum_bits;
  assign unused_sum_bits = ^{y2[18], y2[7:0], pb2[18], pb2[7:0], pr2[18], pr2[7:0]};

`ifdef VIDEO_MIXER_PIPE_YPBPR_FULL_EN
  function automatic logic [7:0] expand(input logic [7:0] v, input logic [8:0] k);
    logic [16:0] p;
    p = (17'(v - 8'd16) * 17'(k)) >> 8;
    return (p > 17'd255) ? 8'hFF : p[7:0];
  endfunction
`else
  logic unused_full;
  assign unused_full = ypbpr_full;
`endif

  logic [7:0] y_c, pb_c, pr_c, r_o, g_o, b_o;
  logic       composite;

  always_comb begin
    y_c  = clamp_int(y2[17:8],  8'd235);
    pb_c = clamp_int(pb2[17:8], 8'd240);
    pr_c = clamp_int(pr2[17:8], 8'd240);
`ifdef VIDEO_MIXER_PIPE_YPBPR_FULL_EN
    if (ypbpr_full) begin
      y_c  = expand(y_c,  9'd298);
      pb_c = expand(pb_c, 9'd291);
      pr_c = expand(pr_c, 9'd291);
    end
`endif
    if (ypbpr) begin
      r_o = pr_c;
      g_o = y_c;
      b_o = pb_c;
    end else begin
      r_o = r2;
      g_o = g2;
      b_o = b2;
    end
    composite = csync | ypbpr;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else begin
      VGA_R  <= r_o[7 -: OUT_W];
      VGA_G  <= g_o[7 -: OUT_W];
      VGA_B  <= b_o[7 -: OUT_W];
      VGA_HS <= composite ? ~(hs2 ^ vs2) : ~hs2;
      VGA_VS <= composite ? 1'b1 : ~vs2;
    end
  end

endmodule
